// File: rtl/ram_read_streamer.sv
// Streams a burst of consecutive RAM words (1-cycle read latency) into a
// valid/ready output through a 2-entry skid FIFO, one word per cycle when unstalled.
module ram_read_streamer #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  // Output handshake: a word transfers on a rising edge where out_valid and
  // out_ready are both 1; out_data/out_valid never change while stalled.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   issue_cnt;
  logic                  inflight;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH-1:0] fifo_q0;
  logic [DATA_WIDTH-1:0] fifo_q1;
  logic                  done_q;

  logic pop;
  logic push;
  logic issue;
  logic accept;
  logic zero_start;
  logic finish;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (issue && issue_cnt == CNT_ONE) state_nxt = DRAIN;
      DRAIN:   if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs; issue only while FIFO occupancy after this edge stays below 2
  always_comb begin
    pop        = out_valid & out_ready;
    push       = inflight;
    accept     = (state == IDLE) && start && (len != '0);
    zero_start = (state == IDLE) && start && (len == '0);
    issue      = (state == RUN) && (issue_cnt != '0) &&
                 (({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
    finish     = (state == DRAIN) && !inflight && (fifo_count == 2'd1) && pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      issue_cnt <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      inflight <= issue;
      done_q   <= zero_start | finish;
      if (accept) begin
        rd_ptr    <= base_addr;
        issue_cnt <= len;
      end else if (issue) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        issue_cnt <= issue_cnt - CNT_ONE;
      end
    end
  end

  // Two-entry FIFO with fifo_q0 always the head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_count <= '0;
      fifo_q0    <= '0;
      fifo_q1    <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_count == 2'd0) fifo_q0 <= ram_q;
          else                    fifo_q1 <= ram_q;
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          fifo_q0    <= fifo_q1;
          fifo_count <= fifo_count - 2'd1;
        end
        2'b11: begin
          if (fifo_count == 2'd1) fifo_q0 <= ram_q;
          else begin
            fifo_q0 <= fifo_q1;
            fifo_q1 <= ram_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_addr  = rd_ptr;
  assign out_data  = fifo_q0;
  assign out_valid = (fifo_count != 2'd0);
  assign busy      = (state != IDLE);
  assign done      = done_q;

endmodule
